neuron: RTL and testbench
=========================

NEURON -- requirements
Module: neuron

Interface
REQ-001 BIAS, default 32'h0001_0000 (+1.0 in Q15.16), meaning the constant bias input multiplied by weight wb.
REQ-002 SIGN, default 1, meaning the number of sign bits in the fixed-point format.
REQ-003 Q_M, default 15, meaning the number of integer bits.
REQ-004 Q_N, default 16, meaning the number of fraction bits; W = SIGN+Q_M+Q_N (default 32).
REQ-005 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 x1_in  input  W  first input operand, two's-complement Q(Q_M).(Q_N).
REQ-008 x2_in  input  W  second input operand, same format.
REQ-009 w1  input  W  weight applied to x1_in, same format.
REQ-010 w2  input  W  weight applied to x2_in, same format.
REQ-011 wb  input  W  weight applied to BIAS, same format.
REQ-012 out  output  W  registered activation; the only legal values are raw 0 and raw 1 (LSB set).

Function
REQ-013 Each product (x1_in*w1, x2_in*w2, BIAS*wb) SHALL be a full 2W-bit signed product, arithmetically shifted right by Q_N, which truncates toward negative infinity.
REQ-014 The shifted product SHALL be reduced to W bits: saturated to the most positive or most negative W-bit value when NEURON_SAT_EN is defined, wrapped otherwise.
REQ-015 The three W-bit terms SHALL be summed at W+2 bits, then reduced to W bits using the same saturate or wrap rule.
REQ-016 Activation is a step function: result = 1 if the sum is strictly greater than 0, otherwise 0; a sum of exactly 0 gives 0.
REQ-017 out SHALL register the activation each rising clk_i edge, giving a latency of one cycle.
REQ-018 The datapath SHALL be fully combinational up to the out register, with no handshake and a throughput of one result per cycle.
REQ-019 Upper bits of out [W-1:1] SHALL always be 0.

Reset
REQ-020 While rst_i is high, out SHALL be 0, taking effect immediately and independent of clk_i.
REQ-021 On rst_i deassertion, the first rising edge SHALL load the activation of the inputs present at that edge.
REQ-022 Reset asserted mid-operation SHALL discard the pending result, with no other state to clear.

Configuration
REQ-023 Macro NEURON_SAT_EN: when defined, the product and sum reductions SHALL saturate (REQ-014, REQ-015).
REQ-024 When NEURON_SAT_EN is undefined, those reductions SHALL wrap by discarding the high bits; port list, latency and reset behaviour SHALL be identical in both builds.

Structure
REQ-025 A shared package neuron_pkg SHALL hold the default SIGN, Q_M and Q_N, derived W, fixed-point ONE (1<<Q_N), and the MAX and MIN saturation constants.
REQ-026 Multiply, shift and reduce SHALL live in one sub-module fxp_mul, parameterized identically and instantiated three times; add and step logic stay in neuron.

Verification
REQ-027 Reset: assert rst_i with arbitrary inputs -> out = 0 immediately; after release it follows the inputs with one-cycle latency.
REQ-028 OR gate: w1 = w2 = 0x0001_0000, wb = 0xFFFF_8000 (-0.5), BIAS = 1.0; x1/x2 drawn from {0, 0x0001_0000}: (0,0) -> out 0; (0,1.0), (1.0,0) and (1.0,1.0) -> out 1, each one cycle after the input is applied.
REQ-029 AND gate: same weights but wb = 0xFFFE_8000 (-1.5) -> only (1.0,1.0) gives out 1; the other three combinations give 0.
REQ-030 Zero boundary: w1 = 1.0, x1_in = 0.5, wb = -0.5, x2_in = 0 -> sum exactly 0 -> out 0.
REQ-031 Overflow: x1_in = w1 = 0x7FFF_0000, w2 = wb = 0 -> with NEURON_SAT_EN out 1 (saturated positive); without it the product wraps to 0x0001_0000 (+1.0) and out is 1; repeat with w1 = 0x8001_0000 (negated) -> saturated build out 0, wrapped build product wraps to -1.0 and out 0.
REQ-032 Truncation: x1_in = raw 1, w1 = 0xFFFF_0000 (-1.0), others 0 -> product is -2^-16 (floor), sum < 0 -> out 0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared fixed-point defaults for the neuron datapath (two's-complement Q15.16).
// Constants here describe the default format; modules derive their own from their parameters.
package neuron_pkg;
    localparam int DEF_SIGN = 1;
    localparam int DEF_Q_M  = 15;
    localparam int DEF_Q_N  = 16;
    localparam int DEF_W    = DEF_SIGN + DEF_Q_M + DEF_Q_N;

    localparam logic [DEF_W-1:0] FXP_ONE = DEF_W'(1) << DEF_Q_N;
    localparam logic [DEF_W-1:0] FXP_MAX = {1'b0, {(DEF_W-1){1'b1}}};
    localparam logic [DEF_W-1:0] FXP_MIN = {1'b1, {(DEF_W-1){1'b0}}};
endpackage

// File: rtl/fxp_mul.sv
// Fixed-point multiply: full signed product, floor shift by Q_N, reduce to W bits.
// NEURON_SAT_EN selects saturating reduction; otherwise the high bits are dropped (wrap).
module fxp_mul
    import neuron_pkg::*;
#(
    parameter int SIGN = DEF_SIGN,
    parameter int Q_M  = DEF_Q_M,
    parameter int Q_N  = DEF_Q_N
) (
    input  logic [SIGN+Q_M+Q_N-1:0] a,
    input  logic [SIGN+Q_M+Q_N-1:0] b,
    output logic [SIGN+Q_M+Q_N-1:0] p
);
    localparam int W = SIGN + Q_M + Q_N;

    logic signed [2*W-1:0] prod;

    assign prod = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});

`ifdef NEURON_SAT_EN
    localparam logic signed [2*W-1:0] MAX_EXT = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] MIN_EXT = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [2*W-1:0] shifted;

    assign shifted = prod >>> Q_N;

    always_comb begin
        p = shifted[W-1:0];
        if (shifted > MAX_EXT)
            p = {1'b0, {(W-1){1'b1}}};
        else if (shifted < MIN_EXT)
            p = {1'b1, {(W-1){1'b0}}};
    end
`else
    assign p = W'(prod >>> Q_N);
`endif
endmodule

// File: rtl/neuron.sv
// Two-input perceptron with bias: three fixed-point products, summed, step-activated, registered.
// NEURON_SAT_EN selects saturating product/sum reduction; default build wraps.
module neuron
    import neuron_pkg::*;
#(
    parameter int SIGN = DEF_SIGN,
    parameter int Q_M  = DEF_Q_M,
    parameter int Q_N  = DEF_Q_N,
    parameter logic [SIGN+Q_M+Q_N-1:0] BIAS = (SIGN+Q_M+Q_N)'(32'h0001_0000)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [SIGN+Q_M+Q_N-1:0] x1_in,
    input  logic [SIGN+Q_M+Q_N-1:0] x2_in,
    input  logic [SIGN+Q_M+Q_N-1:0] w1,
    input  logic [SIGN+Q_M+Q_N-1:0] w2,
    input  logic [SIGN+Q_M+Q_N-1:0] wb,
    output logic [SIGN+Q_M+Q_N-1:0] out
);
    localparam int W = SIGN + Q_M + Q_N;

    logic [W-1:0]          t1, t2, t_b;
    logic signed [W+1:0]   sum_ext;
    logic [W-1:0]          sum_w;
    logic                  act;
    logic                  act_q;

    fxp_mul #(.SIGN(SIGN), .Q_M(Q_M), .Q_N(Q_N)) u_mul_x1 (.a(x1_in), .b(w1), .p(t1));
    fxp_mul #(.SIGN(SIGN), .Q_M(Q_M), .Q_N(Q_N)) u_mul_x2 (.a(x2_in), .b(w2), .p(t2));
    fxp_mul #(.SIGN(SIGN), .Q_M(Q_M), .Q_N(Q_N)) u_mul_b  (.a(BIAS),  .b(wb), .p(t_b));

    // Two guard bits make the three-term sum exact before reduction.
    assign sum_ext = $signed({{2{t1[W-1]}}, t1})
                   + $signed({{2{t2[W-1]}}, t2})
                   + $signed({{2{t_b[W-1]}}, t_b});

`ifdef NEURON_SAT_EN
    localparam logic signed [W+1:0] SUM_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SUM_MIN = {3'b111, {(W-1){1'b0}}};

    always_comb begin
        sum_w = sum_ext[W-1:0];
        if (sum_ext > SUM_MAX)
            sum_w = {1'b0, {(W-1){1'b1}}};
        else if (sum_ext < SUM_MIN)
            sum_w = {1'b1, {(W-1){1'b0}}};
    end
`else
    assign sum_w = W'(sum_ext);
`endif

    // Strictly positive: sign clear and not zero.
    assign act = !sum_w[W-1] && (sum_w != '0);

    // No handshake: a new result is accepted every cycle and appears one edge later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            act_q <= 1'b0;
        else
            act_q <= act;
    end

    assign out = {{(W-1){1'b0}}, act_q};
endmodule

// File: tb/tb_neuron.sv
// Self-checking bench for neuron: directed gate/boundary cases, reset behaviour, random stimulus
// against a plain-arithmetic reference model (honours NEURON_SAT_EN like the design).
module tb_neuron;
    localparam int W = 32;
    localparam logic [W-1:0] ONE = 32'h0001_0000;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [W-1:0] x1_in, x2_in, w1, w2, wb;
    logic [W-1:0] out_w;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    neuron dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .x1_in (x1_in),
        .x2_in (x2_in),
        .w1    (w1),
        .w2    (w2),
        .wb    (wb),
        .out   (out_w)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reduce an exact integer to the W-bit format.
    function automatic longint reduce(input longint v);
        logic signed [W-1:0] t;
`ifdef NEURON_SAT_EN
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
`else
        t = v[W-1:0];
        return longint'(t);
`endif
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] a1, input logic [W-1:0] a2,
                                            input logic [W-1:0] k1, input logic [W-1:0] k2,
                                            input logic [W-1:0] kb);
        longint p1, p2, pb, s;
        p1 = reduce((longint'($signed(a1)) * longint'($signed(k1))) >>> 16);
        p2 = reduce((longint'($signed(a2)) * longint'($signed(k2))) >>> 16);
        pb = reduce((longint'($signed(ONE)) * longint'($signed(kb))) >>> 16);
        s  = reduce(p1 + p2 + pb);
        return (s > 0) ? 32'd1 : 32'd0;
    endfunction

    task automatic drive(input string tag, input logic [W-1:0] a1, input logic [W-1:0] a2,
                         input logic [W-1:0] k1, input logic [W-1:0] k2, input logic [W-1:0] kb);
        @(negedge clk);
        x1_in = a1; x2_in = a2; w1 = k1; w2 = k2; wb = kb;
        exp_q.push_back(model(a1, a2, k1, k2, kb));
        @(posedge clk);
        #1;
        check(tag, out_w, exp_q.pop_front());
    endtask

    function automatic logic [W-1:0] rand_val();
        logic [W-1:0] picks [5] = '{32'h0, 32'h0001_0000, 32'hFFFF_0000, 32'h7FFF_0000, 32'h8000_0000};
        logic [W-1:0] v;
        case ($urandom_range(0, 2))
            0: v = $urandom;
            1: begin
                v = W'($urandom_range(0, 32'h0003_FFFF));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = picks[$urandom_range(0, 4)];
        endcase
        return v;
    endfunction

    initial begin
        rst_i = 1'b1;
        x1_in = ONE; x2_in = ONE; w1 = ONE; w2 = ONE; wb = 32'hFFFF_8000;
        #2;
        check("reset_initial", out_w, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release_first_edge", out_w, 32'd1);

        // OR gate
        drive("or_00", 32'h0, 32'h0, ONE, ONE, 32'hFFFF_8000);
        drive("or_01", 32'h0, ONE,   ONE, ONE, 32'hFFFF_8000);
        drive("or_10", ONE,   32'h0, ONE, ONE, 32'hFFFF_8000);
        drive("or_11", ONE,   ONE,   ONE, ONE, 32'hFFFF_8000);
        check("or_11_const", out_w, 32'd1);

        // AND gate
        drive("and_00", 32'h0, 32'h0, ONE, ONE, 32'hFFFE_8000);
        drive("and_01", 32'h0, ONE,   ONE, ONE, 32'hFFFE_8000);
        drive("and_10", ONE,   32'h0, ONE, ONE, 32'hFFFE_8000);
        check("and_10_const", out_w, 32'd0);
        drive("and_11", ONE,   ONE,   ONE, ONE, 32'hFFFE_8000);

        drive("zero_sum", 32'h0000_8000, 32'h0, ONE, 32'h0, 32'hFFFF_8000);
        check("zero_sum_const", out_w, 32'd0);
        drive("ovf_pos", 32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h0, 32'h0);
        check("ovf_pos_const", out_w, 32'd1);
        drive("ovf_neg", 32'h7FFF_0000, 32'h0, 32'h8001_0000, 32'h0, 32'h0);
        check("ovf_neg_const", out_w, 32'd0);
        drive("trunc_floor", 32'h0000_0001, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0);
        check("trunc_floor_const", out_w, 32'd0);

        // Reset asserted mid-operation clears a pending 1 immediately
        drive("pre_reset_one", ONE, ONE, ONE, ONE, 32'hFFFF_8000);
        #2;
        rst_i = 1'b1;
        #1;
        check("reset_async", out_w, 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold_edge", out_w, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        x1_in = 32'h0; x2_in = 32'h0; wb = 32'h0000_8000;
        @(posedge clk);
        #1;
        check("reset_release_bias", out_w, 32'd1);

        for (int i = 0; i < 300; i++)
            drive("random", rand_val(), rand_val(), rand_val(), rand_val(), rand_val());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
